// File: rtl/weight_pingpong_buf.sv
// weight_pingpong_buf: double-buffered weight store. One bank serves reads
// while the other (shadow) bank is loaded; a swap exchanges their roles.
// Optional macro WEIGHT_BUF_OUTREG_EN adds an output register stage
// (read latency 2 instead of 1).
module weight_pingpong_buf #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DEPTH  = 131072
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              shadow_full,
    output logic [ADDR_W:0]   wr_count,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              active_bank,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    logic              wr_fire;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_oob;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    // Shadow bank only accepts words while not full and not in reset
    assign wr_ready = !shadow_full && !rst;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_idx   = wr_count[IDX_W-1:0];
    assign rd_idx   = rd_addr[IDX_W-1:0];
    assign rd_oob   = (ADDR_W+1)'(rd_addr) >= DEPTH_C;

    // Bank 0 is written only while it is the shadow bank (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_fire && active_bank) begin
            bank0[wr_idx] <= wr_data;
        end
    end

    // Bank 1 is written only while it is the shadow bank (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_fire && !active_bank) begin
            bank1[wr_idx] <= wr_data;
        end
    end

    // Load counter, full flag and bank swap control
    always_ff @(posedge clk) begin
        if (rst) begin
            active_bank <= 1'b0;
            shadow_full <= 1'b0;
            wr_count    <= '0;
            swap_done   <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            if (swap_req && shadow_full) begin
                active_bank <= !active_bank;
                shadow_full <= 1'b0;
                wr_count    <= '0;
                swap_done   <= 1'b1;
            end else if (wr_fire) begin
                wr_count <= wr_count + ONE_C;
                if (wr_last || (wr_count == LAST_C)) begin
                    shadow_full <= 1'b1;
                end
            end
        end
    end

    // Read stage: bank select and address sampled at the rd_en edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                if (rd_oob) begin
                    s1_data <= '0;
                end else if (active_bank) begin
                    s1_data <= bank1[rd_idx];
                end else begin
                    s1_data <= bank0[rd_idx];
                end
            end
        end
    end

`ifdef WEIGHT_BUF_OUTREG_EN
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;

    // Extra output stage; data only advances with a valid word so it holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_data;
            end
        end
    end

    assign rd_valid = s2_valid;
    assign rd_data  = s2_data;
`else
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
`endif

endmodule

// File: tb/tb_weight_pingpong_buf.sv
// tb_weight_pingpong_buf: directed bench on a small build (DEPTH=8, ADDR_W=4).
// Follows WEIGHT_BUF_OUTREG_EN to pick the expected read latency.
module tb_weight_pingpong_buf;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 8;
`ifdef WEIGHT_BUF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              shadow_full;
    logic [ADDR_W:0]   wr_count;
    logic              swap_req;
    logic              swap_done;
    logic              active_bank;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    int n_cmp = 0;
    int n_err = 0;

    weight_pingpong_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .shadow_full(shadow_full), .wr_count(wr_count),
        .swap_req(swap_req), .swap_done(swap_done), .active_bank(active_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [DATA_W-1:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    // Single read, checked after the configured latency, then idle hold check
    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            chk({tag, "_early_valid"}, 32'(rd_valid), 32'd0);
            step();
        end
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
        step();
        chk({tag, "_valid_drop"}, 32'(rd_valid), 32'd0);
        chk({tag, "_hold"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        swap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
        step(); step();
        chk("rst_active_bank", 32'(active_bank), 32'd0);
        chk("rst_shadow_full", 32'(shadow_full), 32'd0);
        chk("rst_wr_count",    32'(wr_count),    32'd0);
        chk("rst_swap_done",   32'(swap_done),   32'd0);
        chk("rst_rd_valid",    32'(rd_valid),    32'd0);
        chk("rst_rd_data",     32'(rd_data),     32'd0);
        chk("rst_wr_ready",    32'(wr_ready),    32'd0);
        rst = 1'b0;
        #1;
        chk("wr_ready_after_rst", 32'(wr_ready), 32'd1);

        // Load 1..4 into bank 1, last on the 4th word
        for (int i = 0; i < 4; i++) begin
            wr_word(DATA_W'(i + 1), i == 3);
            chk("load_wr_count", 32'(wr_count), 32'(i + 1));
            chk("load_shadow_full", 32'(shadow_full), (i == 3) ? 32'd1 : 32'd0);
        end

        // wr_valid held while full: no acceptance, count holds
        wr_valid = 1'b1; wr_data = 4'hF;
        for (int i = 0; i < 3; i++) begin
            chk("full_wr_ready", 32'(wr_ready), 32'd0);
            step();
            chk("full_wr_count", 32'(wr_count), 32'd4);
        end
        wr_valid = 1'b0;

        // Swap: bank 1 becomes active
        do_swap();
        chk("swap1_done", 32'(swap_done), 32'd1);
        chk("swap1_bank", 32'(active_bank), 32'd1);
        chk("swap1_full", 32'(shadow_full), 32'd0);
        chk("swap1_count", 32'(wr_count), 32'd0);
        step();
        chk("swap1_done_pulse", 32'(swap_done), 32'd0);

        // Back-to-back reads of 0..3
        for (int c = 0; c < 4 + LAT; c++) begin
            rd_en   = (c < 4);
            rd_addr = ADDR_W'(c);
            step();
            begin
                int k;
                k = c - (LAT - 1);
                if (k >= 0 && k < 4) begin
                    chk("b2b_valid", 32'(rd_valid), 32'd1);
                    chk("b2b_data", 32'(rd_data), 32'(k + 1));
                end else if (k >= 4) begin
                    chk("b2b_valid_end", 32'(rd_valid), 32'd0);
                end
            end
        end
        rd_en = 1'b0;

        // Swap request while shadow not full is ignored
        do_swap();
        chk("noswap_done", 32'(swap_done), 32'd0);
        chk("noswap_bank", 32'(active_bank), 32'd1);

        // Load A,B,C into bank 0
        wr_word(4'hA, 1'b0);
        wr_word(4'hB, 1'b0);
        wr_word(4'hC, 1'b1);
        chk("load2_full", 32'(shadow_full), 32'd1);

        // Read issued in the swap cycle returns the old bank word
        rd_en = 1'b1; rd_addr = 4'd2; swap_req = 1'b1;
        step();
        rd_en = 1'b0; swap_req = 1'b0;
        chk("swap2_done", 32'(swap_done), 32'd1);
        chk("swap2_bank", 32'(active_bank), 32'd0);
        for (int i = 1; i < LAT; i++) step();
        chk("swapcyc_valid", 32'(rd_valid), 32'd1);
        chk("swapcyc_data", 32'(rd_data), 32'd3);
        step();
        do_read("after_swap", 4'd2, 4'hC);

        // Out-of-range addresses return zero
        do_read("oob_depth", 4'd8, 4'h0);
        do_read("inrange", 4'd1, 4'hB);
        do_read("oob_max", 4'd15, 4'h0);

        // Fill bank 1 to DEPTH without wr_last: full on the last address
        for (int i = 0; i < 8; i++) begin
            wr_word(DATA_W'(i + 1), 1'b0);
            chk("depth_full", 32'(shadow_full), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("depth_count", 32'(wr_count), 32'd8);
        do_swap();
        chk("swap3_bank", 32'(active_bank), 32'd1);
        do_read("depth_last", 4'd7, 4'h8);

        // Reset mid-load at wr_count=2, with a read in flight
        wr_word(4'h5, 1'b0);
        wr_word(4'h6, 1'b0);
        chk("midload_count", 32'(wr_count), 32'd2);
        rd_en = 1'b1; rd_addr = 4'd0;
        step();
        rst = 1'b1; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("midrst_count", 32'(wr_count), 32'd0);
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_bank", 32'(active_bank), 32'd0);
        rst = 1'b0;
        step();
        chk("midrst_valid_after", 32'(rd_valid), 32'd0);
        step();
        chk("midrst_valid_after2", 32'(rd_valid), 32'd0);

        // Reload restarts at address 0 of bank 1; address 2 keeps old contents
        wr_word(4'h9, 1'b0);
        wr_word(4'hA, 1'b1);
        chk("reload_count", 32'(wr_count), 32'd2);
        do_swap();
        chk("swap4_bank", 32'(active_bank), 32'd1);
        do_read("reload_a0", 4'd0, 4'h9);
        do_read("reload_a1", 4'd1, 4'hA);
        do_read("reload_a2", 4'd2, 4'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weight_pingpong_buf.md
WEIGHT_PINGPONG_BUF -- requirements
Module: weight_pingpong_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 4, bits per weight word.
REQ-002 SHALL have parameter ADDR_W, default 17, address width of one bank.
REQ-003 SHALL have parameter DEPTH, default 131072, words per bank; DEPTH <= 2^ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_valid  input  1  load word offered.
REQ-007 SHALL have port wr_ready  output  1  shadow bank accepts a word.
REQ-008 SHALL have port wr_data  input  DATA_W  load word.
REQ-009 SHALL have port wr_last  input  1  final word of the current load.
REQ-010 SHALL have port shadow_full  output  1  shadow bank loaded and awaiting swap.
REQ-011 SHALL have port wr_count  output  ADDR_W+1  words written into the shadow bank.
REQ-012 SHALL have port swap_req  input  1  request to exchange the active and shadow banks.
REQ-013 SHALL have port swap_done  output  1  one-cycle pulse when a swap takes effect.
REQ-014 SHALL have port active_bank  output  1  index of the bank serving reads.
REQ-015 SHALL have port rd_en  input  1  read request.
REQ-016 SHALL have port rd_addr  input  ADDR_W  read address within the active bank.
REQ-017 SHALL have port rd_data  output  DATA_W  read word.
REQ-018 SHALL have port rd_valid  output  1  rd_data valid this cycle.

Function
REQ-019 SHALL hold two banks of DEPTH x DATA_W; the bank not equal to active_bank is the shadow bank.
REQ-020 SHALL write wr_data to shadow[wr_count] and increment wr_count on each cycle with wr_valid && wr_ready.
REQ-021 SHALL drive wr_ready = !shadow_full && !rst.
REQ-022 SHALL set shadow_full on the cycle after an accepted word has wr_last=1 or is written at address DEPTH-1.
REQ-023 SHALL ignore wr_valid while shadow_full=1; no write occurs and wr_count holds.
REQ-024 SHALL, on swap_req=1 with shadow_full=1, toggle active_bank, clear shadow_full, zero wr_count, and pulse swap_done, all at the same edge.
REQ-025 SHALL ignore swap_req while shadow_full=0; swap_done stays 0.
REQ-026 SHALL sample active_bank and rd_addr at the rd_en edge, so a read issued in the swap cycle returns the pre-swap bank.
REQ-027 SHALL return rd_data with rd_valid=1 exactly 1 cycle after rd_en (base latency); rd_valid=0 otherwise.
REQ-028 SHALL return rd_data=0 with rd_valid=1 for rd_addr >= DEPTH.
REQ-029 SHALL hold rd_data at its last value while rd_valid=0.
REQ-030 SHALL accept back-to-back rd_en every cycle at full throughput.
REQ-031 SHALL never write the active bank; reads and loads proceed concurrently.

Reset
REQ-032 SHALL on rst=1 set active_bank=0, shadow_full=0, wr_count=0, swap_done=0, rd_valid=0, rd_data=0, and drop all in-flight reads.
REQ-033 SHALL not clear bank contents on reset; a load interrupted by reset restarts at address 0.

Configuration
REQ-034 SHALL, with macro WEIGHT_BUF_OUTREG_EN defined, add one output register stage, so read latency is 2 cycles, rd_valid is delayed by a matching cycle, and the stage clears on rst.
REQ-035 SHALL, without WEIGHT_BUF_OUTREG_EN, keep read latency at 1 cycle.

Verification
REQ-036 SHALL cover this scenario: load 4 words 0x1,0x2,0x3,0x4 with wr_last on the 4th, then swap_req -> shadow_full=1 after the 4th word, swap_done pulse, active_bank=1, and reads of addresses 0..3 return 1..4 at the configured latency.
REQ-037 SHALL cover this scenario: wr_valid held high with shadow_full=1 -> wr_ready=0 and wr_count stays 4.
REQ-038 SHALL cover this scenario: swap_req with shadow_full=0 -> no swap_done and active_bank unchanged.
REQ-039 SHALL cover this scenario: rd_en addr 2 in the same cycle as the swap -> returns the old bank word, and the next read returns the new bank word.
REQ-040 SHALL cover this scenario: rd_addr=DEPTH (small-DEPTH build, e.g. DEPTH=8, ADDR_W=4) -> rd_valid=1 and rd_data=0.
REQ-041 SHALL cover this scenario: rst asserted mid-load at wr_count=2 -> wr_count=0, rd_valid=0, and a reload writes from address 0.
